// File: rtl/mmio_uart_tx_fifo_if.sv
// Core data-bus view of the memory-mapped UART transmitter.
// master = core load/store port, slave = peripheral.
interface mmio_uart_tx_fifo_if;
    logic [31:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_data_to_mem;
    logic [31:0] mem_data_from_periph;
    logic        periph_sel;

    modport master (
        output mem_address, mem_write, mem_read, mem_data_to_mem,
        input  mem_data_from_periph, periph_sel
    );
    modport slave (
        input  mem_address, mem_write, mem_read, mem_data_to_mem,
        output mem_data_from_periph, periph_sel
    );
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Buffered UART transmitter with its own 16-byte register window:
// TXDATA / STATUS / BAUD_DIV / CTRL, FIFO in front of a framed serialiser.
module mmio_uart_tx_fifo #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic               clk,
    input  logic               rst,
    mmio_uart_tx_fifo_if.slave bus,
    output logic               uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    logic        hit, wr_en, push, push_ok, reject, w1c, pop;
    logic [1:0]  offset;
    logic [31:0] wdata, rdata;

    assign hit    = (bus.mem_address[31:4] == BASE_ADDR[31:4]);
    assign offset = bus.mem_address[3:2];
    assign wdata  = bus.mem_data_to_mem;
    assign wr_en  = hit && bus.mem_write;
    assign push   = wr_en && (offset == 2'd0);
    assign w1c    = wr_en && (offset == 2'd1) && wdata[3];
    assign bus.periph_sel = hit;

    logic unused_bits;
    assign unused_bits = ^{wdata[31:16], bus.mem_address[1:0]};

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q, ovf_d, full, empty;
    logic [15:0]   div_q, div_eff;
    logic [3:0]    ctrl_q;
    logic [7:0]    head;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign push_ok = push && (!full || pop);
    assign reject  = push && !push_ok;
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign head    = mem_q[rptr_q];

    // A rejected push wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (w1c)    ovf_d = 1'b0;
        if (reject) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DEFAULT_DIV;
            ctrl_q  <= 4'b0001;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;
            ovf_q <= ovf_d;
            if (wr_en && offset == 2'd2) div_q  <= wdata[15:0];
            if (wr_en && offset == 2'd3) ctrl_q <= wdata[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata[7:0];
    end

    // Serialiser: frame settings are snapshotted at pop so mid-frame writes only hit later frames.
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, divf_q, divf_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bit_q, bit_d;
    logic        par_q, par_d, pen_q, pen_d, two_q, two_d, stop2_q, stop2_d;
    logic        tx_q, tx_d, bit_end, can_start;

    assign bit_end   = (cnt_q == 16'd0);
    assign can_start = ctrl_q[0] && !empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 16'd1;
        divf_d  = divf_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        par_d   = par_q;
        pen_d   = pen_q;
        two_d   = two_q;
        stop2_d = stop2_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                pop   = can_start;
            end
            START: if (bit_end) begin
                state_d = DATA;
                cnt_d   = divf_q - 16'd1;
                bit_d   = 3'd0;
            end
            DATA: if (bit_end) begin
                cnt_d = divf_q - 16'd1;
                if (bit_q == 3'd7) begin
                    state_d = pen_q ? PARITY : STOP;
                end else begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = sh_q >> 1;
                end
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                cnt_d   = divf_q - 16'd1;
            end
            STOP: if (bit_end) begin
                if (two_q && !stop2_q) begin
                    stop2_d = 1'b1;
                    cnt_d   = divf_q - 16'd1;
                end else if (can_start) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = START;
            sh_d    = head;
            divf_d  = div_eff;
            cnt_d   = div_eff - 16'd1;
            pen_d   = ctrl_q[1];
            two_d   = ctrl_q[3];
            par_d   = (^head) ^ ctrl_q[2];
            stop2_d = 1'b0;
        end
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            divf_q  <= 16'd1;
            sh_q    <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            two_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            divf_q  <= divf_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            two_q   <= two_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
        end
    end

    assign uart_tx = tx_q;

    // Count field is 8 bits wide; only a 256-deep FIFO can exceed it.
    logic [8:0] cnt9;
    logic [7:0] cnt8;
    assign cnt9 = 9'(count_q);
    assign cnt8 = cnt9[8] ? 8'hFF : cnt9[7:0];

    always_comb begin
        rdata = 32'h0;
        if (hit && bus.mem_read) begin
            case (offset)
                2'd1:    rdata = {16'h0, cnt8, 4'h0, ovf_q, (state_q != IDLE), empty, full};
                2'd2:    rdata = {16'h0, div_q};
                2'd3:    rdata = {28'h0, ctrl_q};
                default: rdata = 32'h0;
            endcase
        end
    end
    assign bus.mem_data_from_periph = rdata;
endmodule

// File: tb/tb_mmio_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected reads and serial frames, monitors check them.
module tb_mmio_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_tx;
    mmio_uart_tx_fifo_if bus();

    mmio_uart_tx_fifo dut (.clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx));

    always #5 clk = ~clk;

    typedef struct { logic [11:0] bits; int len; int div; int exp_start; bit contig; string name; } frm_t;
    typedef struct { logic [31:0] data; logic sel; string name; } rdx_t;

    frm_t frm_q[$];
    rdx_t rd_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, prev_end = 0, last_wr = 0;
    bit   in_frame = 1'b0, abort = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_address = a; bus.mem_data_to_mem = d; bus.mem_write = 1'b1;
        @(posedge clk); #1;
        last_wr = cyc; bus.mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic s, input string nm);
        rdx_t r;
        r.data = d; r.sel = s; r.name = nm;
        rd_q.push_back(r);
        bus.mem_address = a; bus.mem_read = 1'b1;
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
    endtask

    task automatic exp_frame(input logic [11:0] b, input int len, input int div,
                             input int start, input bit contig, input string nm);
        frm_t f;
        f.bits = b; f.len = len; f.div = div; f.exp_start = start; f.contig = contig; f.name = nm;
        frm_q.push_back(f);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while ((frm_q.size() != 0 || in_frame) && n < budget) begin
            @(posedge clk); n++;
        end
        if (frm_q.size() != 0 || in_frame) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: %0d frames still pending after %0d cycles, required 0", nm, frm_q.size(), budget);
            frm_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Read-response monitor
    always @(negedge clk) begin
        rdx_t r;
        if (bus.mem_read === 1'b1) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: no expectation queued");
            end else begin
                r = rd_q.pop_front();
                if (bus.mem_data_from_periph !== r.data || bus.periph_sel !== r.sel) begin
                    n_bad++;
                    $display("FAIL %s: data=%h sel=%b, required data=%h sel=%b", r.name,
                             bus.mem_data_from_periph, bus.periph_sel, r.data, r.sel);
                end
            end
        end
    end

    // Serial-line monitor: a falling line starts a frame, sampled every cycle of every bit.
    initial begin : uart_mon
        frm_t f;
        int   start_c, bad_k;
        logic bad_v;
        bit   ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && uart_tx === 1'b0 && !abort) begin
                if (frm_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_start: line low at cycle %0d, required idle high", cyc);
                    while (uart_tx === 1'b0) @(negedge clk);
                end else begin
                    f = frm_q.pop_front();
                    in_frame = 1'b1;
                    start_c = cyc;
                    if (f.contig) begin
                        n_cmp++;
                        if (start_c != prev_end) begin
                            n_bad++;
                            $display("FAIL %s_gap: start cycle %0d, required %0d", f.name, start_c, prev_end);
                        end
                    end else if (f.exp_start >= 0) begin
                        n_cmp++;
                        if (start_c != f.exp_start) begin
                            n_bad++;
                            $display("FAIL %s_latency: start cycle %0d, required %0d", f.name, start_c, f.exp_start);
                        end
                    end
                    bad_k = -1; bad_v = 1'b0; ab = 1'b0;
                    for (int k = 0; k < f.len * f.div; k++) begin
                        if (k != 0) @(negedge clk);
                        if (abort) begin ab = 1'b1; break; end
                        if (bad_k < 0 && uart_tx !== f.bits[k / f.div]) begin
                            bad_k = k; bad_v = uart_tx;
                        end
                    end
                    if (!ab) begin
                        n_cmp++;
                        if (bad_k >= 0) begin
                            n_bad++;
                            $display("FAIL %s: bit %0d cycle %0d line=%b, required %b", f.name,
                                     bad_k / f.div, bad_k % f.div, bad_v, f.bits[bad_k / f.div]);
                        end
                        prev_end = cyc + 1;
                    end
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.mem_address = '0; bus.mem_write = 1'b0; bus.mem_read = 1'b0; bus.mem_data_to_mem = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++; $display("FAIL reset_tx: uart_tx=%b, required 1", uart_tx);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        rd(32'h4004, 32'h0000_0002, 1'b1, "reset_status");
        rd(32'h4008, 32'h0000_01B2, 1'b1, "reset_baud");
        rd(32'h400C, 32'h0000_0001, 1'b1, "reset_ctrl");

        // Single byte, div 4
        wr(32'h4008, 32'd4);
        wr(32'h4000, 32'h55);
        exp_frame({1'b1, 8'h55, 1'b0}, 10, 4, last_wr + 1, 1'b0, "single_55");
        rd(32'h4004, 32'h0000_0100, 1'b1, "status_queued");
        rd(32'h4004, 32'h0000_0006, 1'b1, "status_busy");
        wait_idle(100, "single_55");
        rd(32'h4004, 32'h0000_0002, 1'b1, "status_after_single");

        // Fill and overflow with transmitter disabled, then drain in order
        wr(32'h400C, 32'h0);
        wr(32'h4008, 32'd1);
        for (int i = 0; i < 17; i++) wr(32'h4000, 32'h10 + i);
        rd(32'h4004, 32'h0000_1009, 1'b1, "status_overflow");
        wr(32'h4004, 32'h8);
        rd(32'h4004, 32'h0000_1001, 1'b1, "status_ovf_cleared");
        wr(32'h400C, 32'h1);
        for (int i = 0; i < 16; i++)
            exp_frame({1'b1, 8'(8'h10 + i), 1'b0}, 10, 1, last_wr + 1, i != 0, "drain");
        wait_idle(300, "drain");
        rd(32'h4004, 32'h0000_0002, 1'b1, "status_drained");

        // Back-to-back frames at div 2
        wr(32'h400C, 32'h0);
        wr(32'h4008, 32'd2);
        wr(32'h4000, 32'hA1);
        wr(32'h4000, 32'h3C);
        wr(32'h4000, 32'hFF);
        wr(32'h400C, 32'h1);
        exp_frame(12'b00_1_10100001_0, 10, 2, last_wr + 1, 1'b0, "b2b_a1");
        exp_frame(12'b00_1_00111100_0, 10, 2, -1, 1'b1, "b2b_3c");
        exp_frame(12'b00_1_11111111_0, 10, 2, -1, 1'b1, "b2b_ff");
        wait_idle(200, "b2b");
        rd(32'h4004, 32'h0000_0002, 1'b1, "status_b2b");

        // Odd parity, two stops: parity of 0x07 odd -> 0
        wr(32'h4008, 32'd3);
        wr(32'h400C, 32'hF);
        wr(32'h4000, 32'h07);
        exp_frame(12'b1_1_0_00000111_0, 12, 3, last_wr + 1, 1'b0, "par_odd_2stop");
        wait_idle(100, "par_odd_2stop");
        // Even parity, one stop: parity bit 1
        wr(32'h400C, 32'h3);
        wr(32'h4000, 32'h07);
        exp_frame(12'b0_1_1_00000111_0, 11, 3, last_wr + 1, 1'b0, "par_even");
        wait_idle(100, "par_even");

        // Divisor change mid-frame only affects the next frame
        wr(32'h400C, 32'h1);
        wr(32'h4008, 32'd4);
        wr(32'h4000, 32'h81);
        exp_frame(12'b00_1_10000001_0, 10, 4, last_wr + 1, 1'b0, "div4_frame");
        wr(32'h4000, 32'h42);
        exp_frame(12'b00_1_01000010_0, 10, 8, -1, 1'b1, "div8_frame");
        wr(32'h4008, 32'd8);
        wait_idle(300, "div_change");

        // Clearing enable mid-frame: current frame completes, next waits
        wr(32'h4008, 32'd2);
        wr(32'h4000, 32'h11);
        exp_frame(12'b00_1_00010001_0, 10, 2, last_wr + 1, 1'b0, "en_first");
        wr(32'h4000, 32'h22);
        wr(32'h400C, 32'h0);
        wait_idle(100, "en_first");
        repeat (5) @(posedge clk);
        #1;
        rd(32'h4004, 32'h0000_0100, 1'b1, "status_held");
        wr(32'h400C, 32'h1);
        exp_frame(12'b00_1_00100010_0, 10, 2, last_wr + 1, 1'b0, "en_second");
        wait_idle(100, "en_second");

        // Divisor 0 behaves as 1
        wr(32'h4008, 32'd0);
        rd(32'h4008, 32'h0000_0000, 1'b1, "baud_zero");
        wr(32'h4000, 32'h3A);
        exp_frame(12'b00_1_00111010_0, 10, 1, last_wr + 1, 1'b0, "div0");
        wait_idle(100, "div0");

        // Address decode
        wr(32'h4008, 32'd4);
        rd(32'h3FFC, 32'h0, 1'b0, "decode_below");
        rd(32'h4010, 32'h0, 1'b0, "decode_above");
        wr(32'h4010, 32'h5A);
        wr(32'h4018, 32'h1234);
        rd(32'h4008, 32'h0000_0004, 1'b1, "decode_baud_kept");
        rd(32'h4000, 32'h0, 1'b1, "txdata_reads_zero");
        repeat (10) @(posedge clk);
        #1;
        rd(32'h4004, 32'h0000_0002, 1'b1, "decode_no_push");

        // Reset in the middle of the data bits
        wr(32'h4000, 32'hF0);
        exp_frame(12'b00_1_11110000_0, 10, 4, last_wr + 1, 1'b0, "aborted");
        wr(32'h4000, 32'h0F);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_bad++; $display("FAIL reset_midframe_tx: uart_tx=%b, required 1", uart_tx);
        end
        @(posedge clk); #1;
        rst = 1'b1; abort = 1'b0;
        rd(32'h4004, 32'h0000_0002, 1'b1, "reset_midframe_status");
        rd(32'h4008, 32'h0000_01B2, 1'b1, "reset_midframe_baud");
        rd(32'h400C, 32'h0000_0001, 1'b1, "reset_midframe_ctrl");
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_q.size() != 0 || frm_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftovers: reads=%0d frames=%0d, required 0/0", rd_q.size(), frm_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
